picosoc_mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of one single-port `picosoc_mem` instance (byte-write-enable RAM, registered read, 1-cycle latency).
- Both requester ports use the picorv32 native memory handshake (`valid`/`ready`, byte address, `wstrb`).
  - Port 0: CPU.
  - Port 1: DMA/debug master.
- Grants are round-robin. The arbiter registers the winning request onto the RAM pins, then returns `ready` together with the RAM read data.

---
 rtl/picosoc_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_picosoc_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picosoc_mem_arbiter.sv
// Round-robin arbiter that sequences two picorv32-style requesters onto one
// single-port byte-write RAM with a registered read (IDLE -> ACCESS -> RESP).
module picosoc_mem_arbiter #(
   parameter int WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        p0_valid,
   output logic        p0_ready,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [3:0]  p0_wstrb,
   output logic [31:0] p0_rdata,

   input  logic        p1_valid,
   output logic        p1_ready,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [3:0]  p1_wstrb,
   output logic [31:0] p1_rdata,

   output logic [3:0]  ram_wen,
   output logic [21:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } state_e;

   localparam logic [31:0] WordsLimit = 32'(WORDS);

   state_e      state_q;
   logic        lastGnt_q;
   logic        gnt_q;
   logic        oor_q;
   logic        p0Ready_q;
   logic        p1Ready_q;
   logic [3:0]  wen_q;
   logic [21:0] addr_q;
   logic [31:0] wdata_q;

   logic        gnt_d;
   logic        inRange_d;
   logic [31:0] selAddr;
   logic [31:0] selWdata;
   logic [3:0]  selWstrb;
   logic [31:0] respData;
   logic        unusedAddrBits;

   // With both ports requesting, the one that did not win last time goes next.
   always_comb begin
      gnt_d = 1'b0;
      if (p0_valid && p1_valid) begin
         gnt_d = ~lastGnt_q;
      end else if (p1_valid) begin
         gnt_d = 1'b1;
      end
      selAddr   = gnt_d ? p1_addr  : p0_addr;
      selWdata  = gnt_d ? p1_wdata : p0_wdata;
      selWstrb  = gnt_d ? p1_wstrb : p0_wstrb;
      inRange_d = ({10'd0, selAddr[23:2]} < WordsLimit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         lastGnt_q <= 1'b1;
         gnt_q     <= 1'b0;
         oor_q     <= 1'b0;
         p0Ready_q <= 1'b0;
         p1Ready_q <= 1'b0;
         wen_q     <= 4'b0;
         addr_q    <= 22'd0;
         wdata_q   <= 32'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (p0_valid || p1_valid) begin
                  state_q   <= StAccess;
                  gnt_q     <= gnt_d;
                  lastGnt_q <= gnt_d;
                  oor_q     <= ~inRange_d;
                  addr_q    <= selAddr[23:2];
                  wdata_q   <= selWdata;
                  wen_q     <= inRange_d ? selWstrb : 4'b0;
               end
            end
            StAccess: begin
               // The RAM has taken the write on this edge; clearing wen keeps it single-shot.
               state_q   <= StResp;
               wen_q     <= 4'b0;
               p0Ready_q <= ~gnt_q;
               p1Ready_q <= gnt_q;
            end
            StResp: begin
               state_q   <= StIdle;
               p0Ready_q <= 1'b0;
               p1Ready_q <= 1'b0;
            end
            default: begin
               state_q   <= StIdle;
               p0Ready_q <= 1'b0;
               p1Ready_q <= 1'b0;
               wen_q     <= 4'b0;
            end
         endcase
      end
   end

   assign respData  = oor_q ? 32'h0 : ram_rdata;
   assign p0_rdata  = respData;
   assign p1_rdata  = respData;
   assign p0_ready  = p0Ready_q & ~rst;
   assign p1_ready  = p1Ready_q & ~rst;
   assign ram_wen   = wen_q & {4{~rst}};
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;

   assign unusedAddrBits = ^{p0_addr[31:24], p0_addr[1:0], p1_addr[31:24], p1_addr[1:0]};

endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// Scoreboard bench for picosoc_mem_arbiter with a behavioural 256-word
// byte-write RAM (registered read, read-before-write, index truncated to 8 bits).
module tb_picosoc_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_valid, p1_valid;
   logic        p0_ready, p1_ready;
   logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
   logic [3:0]  p0_wstrb, p1_wstrb;
   logic [31:0] p0_rdata, p1_rdata;
   logic [3:0]  ram_wen;
   logic [21:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic        bdWe;
   logic [7:0]  bdIdx;
   logic [31:0] bdData;
   logic [31:0] mem [0:255];

   int compared = 0;
   int mismatched = 0;
   int p0ReadyCnt = 0;
   int p1ReadyCnt = 0;
   int wenCycles = 0;

   typedef struct packed {
      logic        port;
      logic [31:0] data;
   } exp_t;

   exp_t sbQ[$];

   always #5 clk = ~clk;

   picosoc_mem_arbiter #(.WORDS(256)) dut (
      .clk       (clk),
      .rst       (rst),
      .p0_valid  (p0_valid),
      .p0_ready  (p0_ready),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_wstrb  (p0_wstrb),
      .p0_rdata  (p0_rdata),
      .p1_valid  (p1_valid),
      .p1_ready  (p1_ready),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_wstrb  (p1_wstrb),
      .p1_rdata  (p1_rdata),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // RAM model: upper address bits are ignored, so an unsuppressed out-of-range write aliases onto low words.
   always @(posedge clk) begin
      if (bdWe) begin
         mem[bdIdx] <= bdData;
      end else begin
         ram_rdata <= mem[ram_addr[7:0]];
         for (int b = 0; b < 4; b++) begin
            if (ram_wen[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
         end
      end
   end

   // Activity counters sampled at the rising edge, i.e. the value held through the cycle just ended.
   always @(posedge clk) begin
      if (p0_ready) p0ReadyCnt++;
      if (p1_ready) p1ReadyCnt++;
      if (ram_wen != 4'b0) wenCycles++;
   end

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      @(negedge clk);
      bdWe = 1'b1;
      bdIdx = idx;
      bdData = data;
      @(negedge clk);
      bdWe = 1'b0;
   endtask

   task automatic applyStimulus(input logic port, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
      if (port) begin
         p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb; p1_valid = 1'b1;
      end else begin
         p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb; p0_valid = 1'b1;
      end
   endtask

   task automatic pushExp(input logic port, input logic [31:0] data);
      exp_t e;
      e.port = port;
      e.data = data;
      sbQ.push_back(e);
   endtask

   // Waits (bounded) for a ready strobe and reports what was observed; comparisons stay in the tests.
   task automatic waitReady(input int budget, output bit got, output logic port,
                            output logic [31:0] data, output int cycles);
      got = 1'b0; port = 1'b0; data = 32'h0; cycles = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (p0_ready || p1_ready) begin
            got = 1'b1;
            port = p1_ready;
            data = p1_ready ? p1_rdata : p0_rdata;
            cycles = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      p0_valid = 0; p1_valid = 0;
      p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0; p0_wstrb = 0; p1_wstrb = 0;
      bdWe = 0; bdIdx = 0; bdData = 0;
      repeat (3) @(negedge clk);
      compared++;
      if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_ready: got p0=%b p1=%b, required 0/0", p0_ready, p1_ready);
      end
      compared++;
      if (ram_wen !== 4'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_wen: got %b, required 0000", ram_wen);
      end
      compared++;
      if (ram_addr !== 22'd0 || ram_wdata !== 32'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_ram_bus: got addr=%h wdata=%h, required 0/0", ram_addr, ram_wdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      exp_t e; bit got; logic port; logic [31:0] data; int cyc; int p1Before;
      preload(8'd5, 32'hDEADBEEF);
      p1Before = p1ReadyCnt;
      applyStimulus(1'b0, 32'h14, 32'h0, 4'b0);
      pushExp(1'b0, 32'hDEADBEEF);
      waitReady(10, got, port, data, cyc);
      p0_valid = 1'b0;
      e = sbQ.pop_front();
      compared++;
      if (!got || port !== e.port || data !== e.data) begin
         mismatched++;
         $display("[TB] FAIL single_read: got ready=%0b port=%0d data=%h, required port=%0d data=%h",
                  got, port, data, e.port, e.data);
      end
      compared++;
      if (cyc != 2) begin
         mismatched++;
         $display("[TB] FAIL single_read_latency: got %0d cycles, required 2", cyc);
      end
      @(negedge clk);
      compared++;
      if (p0_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL ready_one_cycle: got p0_ready=%b, required 0", p0_ready);
      end
      @(negedge clk);
      compared++;
      if (p1ReadyCnt != p1Before) begin
         mismatched++;
         $display("[TB] FAIL p1_idle: got %0d p1 ready pulses, required 0", p1ReadyCnt - p1Before);
      end
   endtask

   task automatic test_byte_write();
      exp_t e; bit got; logic port; logic [31:0] data; int cyc; int wenBefore;
      preload(8'd3, 32'h0);
      wenBefore = wenCycles;
      applyStimulus(1'b1, 32'h0C, 32'h11223344, 4'b0101);
      waitReady(10, got, port, data, cyc);
      p1_valid = 1'b0;
      compared++;
      if (!got || port !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL byte_write_ready: got ready=%0b port=%0d, required port 1", got, port);
      end
      @(negedge clk);
      applyStimulus(1'b1, 32'h0C, 32'h0, 4'b0);
      pushExp(1'b1, 32'h00220044);
      waitReady(10, got, port, data, cyc);
      p1_valid = 1'b0;
      e = sbQ.pop_front();
      compared++;
      if (!got || port !== e.port || data !== e.data) begin
         mismatched++;
         $display("[TB] FAIL byte_write_readback: got ready=%0b port=%0d data=%h, required port=%0d data=%h",
                  got, port, data, e.port, e.data);
      end
      @(negedge clk);
      compared++;
      if (wenCycles - wenBefore != 1) begin
         mismatched++;
         $display("[TB] FAIL wen_pulse: got %0d cycles with wen, required 1", wenCycles - wenBefore);
      end
   endtask

   task automatic test_conflict_fairness();
      exp_t e; bit got; logic port; logic [31:0] data; int cyc;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      preload(8'd0, 32'hA0A0A0A0);
      preload(8'd1, 32'hB1B1B1B1);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'b0);
      applyStimulus(1'b1, 32'h4, 32'h0, 4'b0);
      for (int i = 0; i < 4; i++) begin
         pushExp(i[0], i[0] ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
      end
      for (int i = 0; i < 4; i++) begin
         waitReady(10, got, port, data, cyc);
         if (i == 3) begin
            p0_valid = 1'b0;
            p1_valid = 1'b0;
         end
         e = sbQ.pop_front();
         compared++;
         if (!got || port !== e.port || data !== e.data) begin
            mismatched++;
            $display("[TB] FAIL fairness_%0d: got ready=%0b port=%0d data=%h, required port=%0d data=%h",
                     i, got, port, data, e.port, e.data);
         end
         compared++;
         if (cyc != ((i == 0) ? 2 : 3)) begin
            mismatched++;
            $display("[TB] FAIL fairness_spacing_%0d: got %0d cycles, required %0d",
                     i, cyc, (i == 0) ? 2 : 3);
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_out_of_range();
      exp_t e; bit got; logic port; logic [31:0] data; int cyc; int wenBefore;
      preload(8'd0, 32'hCAFEF00D);
      wenBefore = wenCycles;
      applyStimulus(1'b0, 32'h400, 32'hFFFFFFFF, 4'b1111);
      waitReady(10, got, port, data, cyc);
      p0_valid = 1'b0;
      compared++;
      if (!got || port !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL oor_write_ready: got ready=%0b port=%0d, required port 0", got, port);
      end
      @(negedge clk);
      compared++;
      if (wenCycles != wenBefore) begin
         mismatched++;
         $display("[TB] FAIL oor_wen: got %0d cycles with wen, required 0", wenCycles - wenBefore);
      end
      applyStimulus(1'b0, 32'h400, 32'h0, 4'b0);
      pushExp(1'b0, 32'h0);
      waitReady(10, got, port, data, cyc);
      p0_valid = 1'b0;
      e = sbQ.pop_front();
      compared++;
      if (!got || port !== e.port || data !== e.data) begin
         mismatched++;
         $display("[TB] FAIL oor_read: got ready=%0b port=%0d data=%h, required port=%0d data=%h",
                  got, port, data, e.port, e.data);
      end
      @(negedge clk);
      compared++;
      if (mem[0] !== 32'hCAFEF00D) begin
         mismatched++;
         $display("[TB] FAIL oor_mem0: got %h, required cafef00d", mem[0]);
      end
   endtask

   task automatic test_reset_mid_op();
      exp_t e; bit got; logic port; logic [31:0] data; int cyc;
      preload(8'd0, 32'h0F0F0F0F);
      preload(8'd1, 32'h12345678);
      applyStimulus(1'b1, 32'h4, 32'h0, 4'b0);
      waitReady(10, got, port, data, cyc);
      compared++;
      if (!got || port !== 1'b1 || data !== 32'h12345678) begin
         mismatched++;
         $display("[TB] FAIL midop_first_resp: got ready=%0b port=%0d data=%h, required port 1 data 12345678",
                  got, port, data);
      end
      rst = 1'b1;
      p1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      compared++;
      if (p1_ready !== 1'b0 || p0_ready !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL midop_ready_drop: got p0=%b p1=%b, required 0/0", p0_ready, p1_ready);
      end
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'b0);
      applyStimulus(1'b1, 32'h4, 32'h0, 4'b0);
      pushExp(1'b0, 32'h0F0F0F0F);
      pushExp(1'b1, 32'h12345678);
      for (int i = 0; i < 2; i++) begin
         waitReady(10, got, port, data, cyc);
         if (got && port == 1'b0) p0_valid = 1'b0;
         if (got && port == 1'b1) p1_valid = 1'b0;
         e = sbQ.pop_front();
         compared++;
         if (!got || port !== e.port || data !== e.data || cyc != ((i == 0) ? 2 : 3)) begin
            mismatched++;
            $display("[TB] FAIL midop_regrant_%0d: got ready=%0b port=%0d data=%h cycles=%0d, required port=%0d data=%h cycles=%0d",
                     i, got, port, data, cyc, e.port, e.data, (i == 0) ? 2 : 3);
         end
      end
      p0_valid = 1'b0;
      p1_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_field_change();
      exp_t e; bit got; logic port; logic [31:0] data; int cyc;
      preload(8'd2, 32'h22222222);
      preload(8'd3, 32'h33333333);
      applyStimulus(1'b0, 32'h8, 32'h0, 4'b0);
      pushExp(1'b0, 32'h22222222);
      @(negedge clk);
      p0_addr = 32'hC;
      waitReady(10, got, port, data, cyc);
      p0_valid = 1'b0;
      e = sbQ.pop_front();
      compared++;
      if (!got || port !== e.port || data !== e.data) begin
         mismatched++;
         $display("[TB] FAIL field_change: got ready=%0b port=%0d data=%h, required port=%0d data=%h",
                  got, port, data, e.port, e.data);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_byte_write();
      test_conflict_fairness();
      test_out_of_range();
      test_reset_mid_op();
      test_field_change();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
